// File: rtl/trigger_scheduler.sv
// Drum step sequencer: stores a NUM_VOICES x NUM_STEPS velocity pattern and,
// once per tempo period, scans every voice of the current step (one voice per
// clock), presenting a registered select/velocity pair and a trigger strobe.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   run_i         1 = running, 0 = stopped (aborts scan, clears status)
//   tempo_div_i   step period in clocks minus 1
//   pat_we_i      pattern write strobe
//   pat_voice_i   pattern write voice index
//   pat_step_i    pattern write step index
//   pat_vel_i     pattern write velocity (0 = no hit)
//   sel_o         voice index to demux
//   vel_o         velocity to demux
//   trig_valid_o  one-cycle strobe qualifying sel_o/vel_o
//   step_o        step currently or last played
//   step_tick_o   one-cycle pulse at the start of each step scan
//   busy_o        high while scanning
//   overrun_o     sticky: a tempo tick arrived during a scan
module trigger_scheduler #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned SEL_WIDTH  = 3,
    parameter int unsigned STEP_WIDTH = 4,
    parameter int unsigned VEL_WIDTH  = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    input  logic [DIV_WIDTH-1:0]  tempo_div_i,
    input  logic                  pat_we_i,
    input  logic [SEL_WIDTH-1:0]  pat_voice_i,
    input  logic [STEP_WIDTH-1:0] pat_step_i,
    input  logic [VEL_WIDTH-1:0]  pat_vel_i,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [VEL_WIDTH-1:0]  vel_o,
    output logic                  trig_valid_o,
    output logic [STEP_WIDTH-1:0] step_o,
    output logic                  step_tick_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [SEL_WIDTH-1:0]  LAST_VOICE = SEL_WIDTH'(NUM_VOICES - 1);
    localparam logic [STEP_WIDTH-1:0] LAST_STEP  = STEP_WIDTH'(NUM_STEPS - 1);

    logic [VEL_WIDTH-1:0]  pattern [NUM_VOICES][NUM_STEPS];

    logic [1:0]            state, state_n;
    logic [SEL_WIDTH-1:0]  voice, voice_n;
    logic [STEP_WIDTH-1:0] step, step_n;
    logic [DIV_WIDTH-1:0]  count, count_n;

    logic [SEL_WIDTH-1:0]  sel_n;
    logic [VEL_WIDTH-1:0]  vel_n;
    logic                  trig_n;
    logic [STEP_WIDTH-1:0] step_o_n;
    logic                  step_tick_n;
    logic                  busy_n;
    logic                  overrun_n;

    logic                  wr_ok_c;
    logic                  tick_c;
    logic [VEL_WIDTH-1:0]  rd_vel_c;
    logic [DIV_WIDTH-1:0]  count_adv_c;

    // Out-of-range write indices are silently dropped.
    assign wr_ok_c = pat_we_i
                   && (32'(pat_voice_i) < NUM_VOICES)
                   && (32'(pat_step_i) < NUM_STEPS);

    // Pattern storage; a same-cycle write is seen by the next scan read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                for (int unsigned s = 0; s < NUM_STEPS; s++) begin
                    pattern[v][s] <= '0;
                end
            end
        end else if (wr_ok_c) begin
            pattern[pat_voice_i][pat_step_i] <= pat_vel_i;
        end
    end

    assign rd_vel_c = pattern[voice][step];

    // Free-running tempo divider; equality compare so a lowered divisor lets
    // the counter run through its natural wrap before matching again.
    assign tick_c      = (count == tempo_div_i);
    assign count_adv_c = tick_c ? '0 : count + DIV_WIDTH'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        voice_n     = voice;
        step_n      = step;
        count_n     = count;
        sel_n       = sel_o;
        vel_n       = vel_o;
        trig_n      = 1'b0;
        step_o_n    = step_o;
        step_tick_n = 1'b0;
        busy_n      = 1'b0;
        overrun_n   = overrun_o;

        if (!run_i) begin
            state_n   = IDLE;
            voice_n   = '0;
            step_n    = '0;
            count_n   = '0;
            sel_n     = '0;
            vel_n     = '0;
            step_o_n  = '0;
            overrun_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_n     = SCAN;
                    voice_n     = '0;
                    count_n     = '0;
                    step_tick_n = 1'b1;
                    busy_n      = 1'b1;
                    step_o_n    = step;
                end
                SCAN: begin
                    count_n = count_adv_c;
                    sel_n   = voice;
                    vel_n   = rd_vel_c;
                    trig_n  = |rd_vel_c;
                    // Ticks landing mid-scan are dropped but remembered.
                    if (tick_c) begin
                        overrun_n = 1'b1;
                    end
                    if (voice == LAST_VOICE) begin
                        voice_n = '0;
                        step_n  = (step == LAST_STEP) ? '0 : step + STEP_WIDTH'(1);
                        state_n = WAIT;
                    end else begin
                        voice_n = voice + SEL_WIDTH'(1);
                        busy_n  = 1'b1;
                    end
                end
                WAIT: begin
                    count_n = count_adv_c;
                    if (tick_c) begin
                        state_n     = SCAN;
                        voice_n     = '0;
                        step_tick_n = 1'b1;
                        busy_n      = 1'b1;
                        step_o_n    = step;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            voice        <= '0;
            step         <= '0;
            count        <= '0;
            sel_o        <= '0;
            vel_o        <= '0;
            trig_valid_o <= 1'b0;
            step_o       <= '0;
            step_tick_o  <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            state        <= state_n;
            voice        <= voice_n;
            step         <= step_n;
            count        <= count_n;
            sel_o        <= sel_n;
            vel_o        <= vel_n;
            trig_valid_o <= trig_n;
            step_o       <= step_o_n;
            step_tick_o  <= step_tick_n;
            busy_o       <= busy_n;
            overrun_o    <= overrun_n;
        end
    end

endmodule
